// File: rtl/top_uart.sv
// top_uart: 32-bit word UART transceiver with internal serial loopback.
// A word is sent as four 8N1 frames (LSB byte first), looped back from the
// TX line into the RX path, and reassembled into a 32-bit word.
//
// Optional feature macro: UART_PARITY_EN adds an even-parity bit after data
// bit 7 (8E1 framing). RX drops the byte on a parity mismatch.
//
// Ports:
//   clk                in   system clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   i_sys_data         in   [31:0] TX word, sampled on the accept cycle
//   sys_tx_data_valid  in   TX request, accepted when word_busy is low
//   o_sys_data         out  [31:0] last complete received word
//   sys_rx_data_valid  out  one-cycle pulse the cycle after o_sys_data loads
//   word_busy          out  high while a TX word is in flight
module top_uart #(
    parameter int unsigned CLKS_PER_BIT   = 27,
    parameter int unsigned BYTES_PER_WORD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_sys_data,
    input  logic        sys_tx_data_valid,
    output logic [31:0] o_sys_data,
    output logic        sys_rx_data_valid,
    output logic        word_busy
);

    localparam int unsigned WORD_W   = 8 * BYTES_PER_WORD;
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIDX_W   = $clog2(BYTES_PER_WORD);
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(HALF_BIT - 1);
    localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // ---------------- TX ----------------
    tx_state_e          tx_state_q, tx_state_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]         tx_bit_q, tx_bit_d;
    logic [BIDX_W-1:0]  tx_byte_idx_q, tx_byte_idx_d;
    logic [WORD_W-1:0]  tx_word_q, tx_word_d;
    logic               tx_line_q, tx_line_d;
    logic               busy_q, busy_d;
    logic [7:0]         tx_cur_byte_c;
    logic               tx_bit_end_c;

    assign tx_cur_byte_c = tx_word_q[{tx_byte_idx_q, 3'b000} +: 8];
    assign tx_bit_end_c  = (tx_cnt_q == CNT_LAST);

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_byte_idx_q <= '0;
            tx_word_q     <= '0;
            tx_line_q     <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_byte_idx_q <= tx_byte_idx_d;
            tx_word_q     <= tx_word_d;
            tx_line_q     <= tx_line_d;
            busy_q        <= busy_d;
        end
    end

    // TX next state; the line register is loaded with the level of the bit
    // being entered so it changes on the same edge as the state.
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q;
        tx_bit_d      = tx_bit_q;
        tx_byte_idx_d = tx_byte_idx_q;
        tx_word_d     = tx_word_q;
        tx_line_d     = tx_line_q;
        busy_d        = busy_q;

        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_bit_end_c ? '0 : tx_cnt_q + CNT_W'(1);
        end

        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (sys_tx_data_valid && !busy_q) begin
                    tx_word_d     = i_sys_data;
                    tx_byte_idx_d = '0;
                    tx_cnt_d      = '0;
                    tx_line_d     = 1'b0;
                    busy_d        = 1'b1;
                    tx_state_d    = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end_c) begin
                    tx_bit_d   = '0;
                    tx_line_d  = tx_cur_byte_c[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end_c) begin
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_line_d  = ^tx_cur_byte_c;
                        tx_state_d = TX_PARITY;
`else
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
`endif
                    end else begin
                        tx_bit_d  = tx_bit_q + 3'd1;
                        tx_line_d = tx_cur_byte_c[tx_bit_q + 3'd1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_bit_end_c) begin
                    tx_line_d  = 1'b1;
                    tx_state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (tx_bit_end_c) begin
                    if (tx_byte_idx_q == BYTE_LAST) begin
                        busy_d     = 1'b0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        // Next frame starts immediately, no idle gap
                        tx_byte_idx_d = tx_byte_idx_q + BIDX_W'(1);
                        tx_line_d     = 1'b0;
                        tx_state_d    = TX_START;
                    end
                end
            end
            default: begin
                tx_line_d  = 1'b1;
                busy_d     = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // ---------------- RX ----------------
    rx_state_e          rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic [BIDX_W-1:0]  rx_byte_cnt_q, rx_byte_cnt_d;
    logic [WORD_W-1:0]  rx_word_q, rx_word_d;
    logic [WORD_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_load_q, rx_load_d;
    logic               rx_valid_q;
    logic               rx_sync1_q, rx_sync2_q;
    logic               rx_in_c;
    logic               rx_sample_c;
    logic               rx_frame_ok_c;

`ifdef UART_PARITY_EN
    logic               rx_par_ok_q, rx_par_ok_d;
    assign rx_frame_ok_c = rx_in_c && rx_par_ok_q;
`else
    assign rx_frame_ok_c = rx_in_c;
`endif

    assign rx_in_c = rx_sync2_q;
    // Start bit is checked half a bit in; every later sample is one full bit on
    assign rx_sample_c = (rx_state_q == RX_START) ? (rx_cnt_q == CNT_HALF)
                                                  : (rx_cnt_q == CNT_LAST);

    // Two-flop synchronizer on the looped-back line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            rx_sync1_q <= tx_line_q;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_byte_q     <= '0;
            rx_byte_cnt_q <= '0;
            rx_word_q     <= '0;
            rx_data_q     <= '0;
            rx_load_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_ok_q   <= 1'b0;
`endif
        end else begin
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_byte_q     <= rx_byte_d;
            rx_byte_cnt_q <= rx_byte_cnt_d;
            rx_word_q     <= rx_word_d;
            rx_data_q     <= rx_data_d;
            rx_load_q     <= rx_load_d;
            rx_valid_q    <= rx_load_q;
`ifdef UART_PARITY_EN
            rx_par_ok_q   <= rx_par_ok_d;
`endif
        end
    end

    // RX next state and word assembly
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_byte_d     = rx_byte_q;
        rx_byte_cnt_d = rx_byte_cnt_q;
        rx_word_d     = rx_word_q;
        rx_data_d     = rx_data_q;
        rx_load_d     = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_ok_d   = rx_par_ok_q;
`endif

        if (rx_state_q != RX_IDLE) begin
            rx_cnt_d = rx_sample_c ? '0 : rx_cnt_q + CNT_W'(1);
        end

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_in_c) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_sample_c) begin
                    rx_bit_d   = '0;
                    // A start bit that is gone by mid-bit was a glitch
                    rx_state_d = rx_in_c ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_sample_c) begin
                    rx_byte_d = {rx_in_c, rx_byte_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_sample_c) begin
                    rx_par_ok_d = (rx_in_c == ^rx_byte_q);
                    rx_state_d  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                // Return to idle at mid stop bit so the next start edge is seen
                if (rx_sample_c) begin
                    rx_state_d = RX_IDLE;
                    if (rx_frame_ok_c) begin
                        rx_word_d[{rx_byte_cnt_q, 3'b000} +: 8] = rx_byte_q;
                        if (rx_byte_cnt_q == BYTE_LAST) begin
                            rx_data_d     = rx_word_d;
                            rx_load_d     = 1'b1;
                            rx_byte_cnt_d = '0;
                        end else begin
                            rx_byte_cnt_d = rx_byte_cnt_q + BIDX_W'(1);
                        end
                    end else begin
                        rx_byte_cnt_d = '0;
                    end
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    assign o_sys_data        = rx_data_q;
    assign sys_rx_data_valid = rx_valid_q;
    assign word_busy         = busy_q;

endmodule

// File: tb/tb_top_uart.sv
// tb_top_uart: directed, table-driven bench for top_uart (loopback UART).
// A line monitor decodes frames from the internal TX line independently.
module tb_top_uart;

    localparam int unsigned CPB = 27;
`ifdef UART_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned WORD_CLKS = 4 * FRAME_BITS * CPB;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_sys_data;
    logic        sys_tx_data_valid;
    logic [31:0] o_sys_data;
    logic        sys_rx_data_valid;
    logic        word_busy;

    top_uart #(
        .CLKS_PER_BIT   (CPB),
        .BYTES_PER_WORD (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_sys_data        (i_sys_data),
        .sys_tx_data_valid (sys_tx_data_valid),
        .o_sys_data        (o_sys_data),
        .sys_rx_data_valid (sys_rx_data_valid),
        .word_busy         (word_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tx;
        logic [31:0] exp_rx;
        int          hold;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int vcnt = 0;
    int wide_pulse = 0;
    logic prev_valid = 1'b0;
    int mon_err = 0;
    int rst_events = 0;
    logic [7:0] mon_q[$];
    logic [7:0] mon_b;
    int mon_rst0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Valid pulse counting and width monitor
    always @(negedge clk) begin
        if (sys_rx_data_valid) vcnt++;
        if (sys_rx_data_valid && prev_valid) wide_pulse++;
        prev_valid = sys_rx_data_valid;
    end

    always @(negedge rst_n) rst_events++;

    // Independent frame decoder on the serial line
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && dut.tx_line_q == 1'b0) begin
                mon_rst0 = rst_events;
                repeat (CPB / 2) @(negedge clk);
                if (dut.tx_line_q == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        mon_b[i] = dut.tx_line_q;
                    end
`ifdef UART_PARITY_EN
                    repeat (CPB) @(negedge clk);
                    if (rst_events == mon_rst0 && dut.tx_line_q !== ^mon_b) mon_err++;
`endif
                    repeat (CPB) @(negedge clk);
                    if (rst_events == mon_rst0) begin
                        if (dut.tx_line_q !== 1'b1) mon_err++;
                        mon_q.push_back(mon_b);
                    end
                end
            end
        end
    end

    // Send one word and check busy timing, latency, data, pulse count, line bytes
    task automatic run_vec(input vec_t v);
        int cycles = 0;
        int busy_cnt = 0;
        int lat = 0;
        int v0;
        logic got = 1'b0;
        logic [31:0] exp_word;
        logic [7:0] exp_b;
        exp_word = v.exp_rx;
        mon_q.delete();
        v0 = vcnt;
        i_sys_data = v.tx;
        sys_tx_data_valid = 1'b1;
        while (cycles < 2 * WORD_CLKS && !(got && !word_busy && cycles >= v.hold)) begin
            @(negedge clk);
            cycles++;
            if (word_busy) busy_cnt++;
            if (cycles == 1) check("busy_after_accept", 32'(word_busy), 32'd1);
            if (cycles == v.hold) begin
                sys_tx_data_valid = 1'b0;
                i_sys_data = ~v.tx;
            end
            if (sys_rx_data_valid && !got) begin
                got = 1'b1;
                lat = cycles;
                check("rx_data_at_valid", o_sys_data, exp_word);
            end
        end
        sys_tx_data_valid = 1'b0;
        check("rx_valid_seen", 32'(got), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(WORD_CLKS));
        checks++;
        if (!(lat >= int'(WORD_CLKS) - 30 && lat <= int'(WORD_CLKS))) begin
            errors++;
            $display("FAIL latency actual=%0d required=%0d..%0d", lat, WORD_CLKS - 30, WORD_CLKS);
        end
        repeat (100) @(negedge clk);
        check("rx_data_stable", o_sys_data, exp_word);
        check("valid_pulses", 32'(vcnt - v0), 32'd1);
        check("line_byte_count", 32'(mon_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            exp_b = exp_word[8*k +: 8];
            check($sformatf("line_byte%0d", k),
                  (k < mon_q.size()) ? 32'(mon_q[k]) : 32'hFFFF_FFFF, 32'(exp_b));
        end
    endtask

    vec_t vecs[8];
    vec_t vlast;
    int v0r;

    initial begin
        vecs[0] = '{tx: 32'h66666666, exp_rx: 32'h66666666, hold: 1};
        vecs[1] = '{tx: 32'h77777777, exp_rx: 32'h77777777, hold: 1};
        vecs[2] = '{tx: 32'hFFFFFFFF, exp_rx: 32'hFFFFFFFF, hold: 1};
        vecs[3] = '{tx: 32'h12345678, exp_rx: 32'h12345678, hold: 1};
        vecs[4] = '{tx: 32'hA5A5A5A5, exp_rx: 32'hA5A5A5A5, hold: 2};
        vecs[5] = '{tx: 32'h00000000, exp_rx: 32'h00000000, hold: 1};
        vecs[6] = '{tx: 32'h80000001, exp_rx: 32'h80000001, hold: 1};
        vecs[7] = '{tx: 32'h0F0F0F0F, exp_rx: 32'h0F0F0F0F, hold: 1};

        rst_n = 1'b0;
        i_sys_data = 32'h0;
        sys_tx_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", o_sys_data, 32'h0);
        check("reset_valid", 32'(sys_rx_data_valid), 32'd0);
        check("reset_busy", 32'(word_busy), 32'd0);
        check("reset_line", 32'(dut.tx_line_q), 32'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of byte 2
        i_sys_data = 32'hCAFEBABE;
        sys_tx_data_valid = 1'b1;
        @(negedge clk);
        sys_tx_data_valid = 1'b0;
        repeat (2 * FRAME_BITS * CPB + 4 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", o_sys_data, 32'h0);
        check("midrst_valid", 32'(sys_rx_data_valid), 32'd0);
        check("midrst_busy", 32'(word_busy), 32'd0);
        check("midrst_line", 32'(dut.tx_line_q), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0r = vcnt;
        repeat (WORD_CLKS + 200) @(negedge clk);
        check("midrst_no_pulse", 32'(vcnt - v0r), 32'd0);
        check("midrst_data_held", o_sys_data, 32'h0);

        vlast = '{tx: 32'hDEADBEEF, exp_rx: 32'hDEADBEEF, hold: 1};
        run_vec(vlast);

        check("single_cycle_pulses", 32'(wide_pulse), 32'd0);
        check("line_frame_errors", 32'(mon_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
